// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types for the codec sample paths
//
// Purpose: common sample width, stereo sample record and transmitter state
// encoding used by the DAC transmitter and its sample FIFO.
// Ports: none (package).

package audio_pkg;

   localparam int SAMPLE_W = 24;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] left;
      logic signed [SAMPLE_W-1:0] right;
   } stereo_sample_t;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      DELAY      = 2'd1,
      SHIFT      = 2'd2,
      PAD        = 2'd3
   } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous FIFO of stereo sample records
//
// Purpose: small first-word-fall-through FIFO; the head entry is always
// visible on pop_data so the consumer can take it in the same cycle it pops.
// Ports:
//   CLOCK_50   system clock
//   reset      synchronous, active-high; empties the FIFO
//   push       store push_data (ignored when full)
//   push_data  entry to store
//   pop        advance past the head entry (ignored when empty)
//   pop_data   head entry, valid while empty is low
//   count      entries currently stored
//   full       count == DEPTH
//   empty      count == 0

module sample_fifo
   import audio_pkg::*;
#(
   parameter type T     = stereo_sample_t,
   parameter int  DEPTH = 4
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output T                         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T                mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset; only the pointers and count define contents.
   always_ff @(posedge CLOCK_50) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// rtl/i2s_dac_transmitter.sv - I2S serializer for the WM8731 DAC (codec is bus master)
//
// Purpose: buffers stereo samples from the effects path and shifts them out
// MSB first on AUD_DACDAT, one BCLK after each LRCK edge.
// Ports:
//   CLOCK_50         system clock, 50 MHz
//   reset            synchronous, active-high
//   write            push request, accepted when write && write_ready
//   writedata_left   signed left sample
//   writedata_right  signed right sample
//   write_ready      FIFO not full (low while in reset)
//   AUD_BCLK         codec bit clock, asynchronous
//   AUD_DACLRCK      codec LR clock, low = left, high = right
//   AUD_DACDAT       serial data to the codec
//   underflow        one-cycle pulse when a frame starts with the FIFO empty
//   fifo_count       entries currently stored

module i2s_dac_transmitter
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            CLOCK_50,
   input  logic                            reset,
   input  logic                            write,
   input  logic signed [DATA_WIDTH-1:0]    writedata_left,
   input  logic signed [DATA_WIDTH-1:0]    writedata_right,
   output logic                            write_ready,
   input  logic                            AUD_BCLK,
   input  logic                            AUD_DACLRCK,
   output logic                            AUD_DACDAT,
   output logic                            underflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [1:0] ST_WAIT_FRAME = 2'(WAIT_FRAME);
   localparam logic [1:0] ST_DELAY      = 2'(DELAY);
   localparam logic [1:0] ST_SHIFT      = 2'(SHIFT);
   localparam logic [1:0] ST_PAD        = 2'(PAD);

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] left;
      logic signed [DATA_WIDTH-1:0] right;
   } frame_t;

   // ------------------------------------------------------------------
   // Codec clock synchronizers: 2-FF sync plus a history flop each.
   // ------------------------------------------------------------------
   logic bclk_meta, bclk_sync, bclk_hist;
   logic lrck_meta, lrck_sync, lrck_hist;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         bclk_meta <= 1'b0;
         bclk_sync <= 1'b0;
         bclk_hist <= 1'b0;
         lrck_meta <= 1'b0;
         lrck_sync <= 1'b0;
         lrck_hist <= 1'b0;
      end else begin
         bclk_meta <= AUD_BCLK;
         bclk_sync <= bclk_meta;
         bclk_hist <= bclk_sync;
         lrck_meta <= AUD_DACLRCK;
         lrck_sync <= lrck_meta;
         lrck_hist <= lrck_sync;
      end
   end

   logic bclk_fall;
   assign bclk_fall = bclk_hist & ~bclk_sync;

   // ------------------------------------------------------------------
   // Sample FIFO
   // ------------------------------------------------------------------
   frame_t fifo_din;
   frame_t fifo_dout;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_push;
   logic   pop_req;

   assign write_ready    = !reset && !fifo_full;
   assign fifo_push      = write && write_ready;
   assign fifo_din.left  = writedata_left;
   assign fifo_din.right = writedata_right;

   sample_fifo #(
      .T     (frame_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_din),
      .pop       (pop_req),
      .pop_data  (fifo_dout),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Shifter
   // ------------------------------------------------------------------
   logic [1:0]                   state;
   logic                         lrck_last;   // lrck seen at the previous bclk_fall
   logic signed [DATA_WIDTH-1:0] hold_l;
   logic signed [DATA_WIDTH-1:0] hold_r;
   logic [DATA_WIDTH-1:0]        shreg;
   logic [CNT_W-1:0]             bit_cnt;     // data bits already driven this channel
   logic                         lrck_fall;
   logic                         lrck_rise;
   logic [DATA_WIDTH-1:0]        word;

   assign lrck_fall = lrck_last & ~lrck_sync;
   assign lrck_rise = ~lrck_last & lrck_sync;
   // Every left-channel boundary pops, whatever the shifter was doing.
   assign pop_req   = bclk_fall & lrck_fall;
   assign word      = lrck_sync ? hold_r : hold_l;

   // lrck_last resets low so a reset while LRCK is high cannot fake a
   // falling edge; output resumes only at a real left boundary.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= ST_WAIT_FRAME;
         lrck_last  <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         AUD_DACDAT <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         underflow <= pop_req && fifo_empty;
         if (bclk_fall) begin
            lrck_last <= lrck_sync;
            if (lrck_fall) begin
               // Both halves latched together keeps left/right paired.
               hold_l     <= fifo_empty ? '0 : fifo_dout.left;
               hold_r     <= fifo_empty ? '0 : fifo_dout.right;
               state      <= ST_DELAY;
               AUD_DACDAT <= 1'b0;
            end else if (lrck_rise && (state != ST_WAIT_FRAME)) begin
               state      <= ST_DELAY;
               AUD_DACDAT <= 1'b0;
            end else begin
               case (state)
                  ST_WAIT_FRAME: begin
                     AUD_DACDAT <= 1'b0;
                  end
                  ST_DELAY: begin
                     // The delay slot has elapsed; the MSB goes out now.
                     AUD_DACDAT <= word[DATA_WIDTH-1];
                     shreg      <= {word[DATA_WIDTH-2:0], 1'b0};
                     bit_cnt    <= CNT_W'(1);
                     state      <= ST_SHIFT;
                  end
                  ST_SHIFT: begin
                     if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                        AUD_DACDAT <= 1'b0;
                        state      <= ST_PAD;
                     end else begin
                        AUD_DACDAT <= shreg[DATA_WIDTH-1];
                        shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + 1'b1;
                     end
                  end
                  ST_PAD: begin
                     AUD_DACDAT <= 1'b0;
                  end
                  default: begin
                     state      <= ST_WAIT_FRAME;
                     AUD_DACDAT <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   // lrck_hist completes the synchronizer pipeline for symmetry with BCLK;
   // LRCK edges are taken relative to bclk_fall via lrck_last instead.
   logic unused_lrck_hist;
   assign unused_lrck_hist = lrck_hist;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb/tb_i2s_dac_transmitter.sv - scoreboard bench for the I2S DAC transmitter

module tb_i2s_dac_transmitter;

   logic               CLOCK_50 = 1'b0;
   logic               reset;
   logic               write;
   logic signed [23:0] writedata_left;
   logic signed [23:0] writedata_right;
   logic               write_ready;
   logic               AUD_BCLK;
   logic               AUD_DACLRCK;
   logic               AUD_DACDAT;
   logic               underflow;
   logic [2:0]         fifo_count;

   int checks = 0;
   int errors = 0;
   int chan_num = 0;
   int chan_len = 32;

   typedef struct {
      int          chan;
      logic [31:0] bits;
      int          n;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   i2s_dac_transmitter #(
      .DATA_WIDTH (24),
      .FIFO_DEPTH (4)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .write_ready     (write_ready),
      .AUD_BCLK        (AUD_BCLK),
      .AUD_DACLRCK     (AUD_DACLRCK),
      .AUD_DACDAT      (AUD_DACDAT),
      .underflow       (underflow),
      .fifo_count      (fifo_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Codec model: BCLK = 20 CLOCK_50 cycles, LRCK toggles on BCLK falls.
   initial begin
      int slot;
      slot = 0;
      AUD_BCLK = 1'b0;
      AUD_DACLRCK = 1'b0;
      forever begin
         repeat (10) @(negedge CLOCK_50);
         AUD_BCLK = 1'b1;
         repeat (10) @(negedge CLOCK_50);
         AUD_BCLK = 1'b0;
         slot++;
         if (slot >= chan_len) begin
            slot = 0;
            chan_num++;
            AUD_DACLRCK = ~AUD_DACLRCK;
         end
      end
   end

   initial begin
      repeat (40000) @(posedge CLOCK_50);
      $display("FAIL watchdog: simulation still running after 40000 cycles, required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Expected channel bits: delay slot, then up to 24 data bits MSB first, then zeros.
   function automatic logic [31:0] mk_exp(input logic [23:0] w, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         r = {r[30:0], ((i >= 1) && (i <= 24)) ? w[24-i] : 1'b0};
      end
      return r;
   endfunction

   task automatic expect_ch(input int ch, input logic [31:0] bits, input int n, input string nm);
      exp_t e;
      e.chan = ch;
      e.bits = bits;
      e.n    = n;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic finish_channel(input int ch, input logic [31:0] cap, input int ncap);
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].chan < ch) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: channel %0d never captured, expected %0h", e.name, e.chan, e.bits);
      end
      if (exp_q.size() > 0 && exp_q[0].chan == ch) begin
         e = exp_q.pop_front();
         checks++;
         if (ncap != e.n || cap !== e.bits) begin
            errors++;
            $display("FAIL %s: chan %0d got %0d bits %0h, expected %0d bits %0h",
                     e.name, ch, ncap, cap, e.n, e.bits);
         end
      end
   endtask

   // Monitor: captures AUD_DACDAT on each BCLK rise, one word per LRCK channel.
   initial begin
      logic        prev_lr;
      logic [31:0] cap;
      int          ncap;
      int          cap_chan;
      bit          started;
      started = 0;
      prev_lr = 1'b0;
      cap = '0;
      ncap = 0;
      cap_chan = 0;
      forever begin
         @(posedge AUD_BCLK);
         if (!started || AUD_DACLRCK != prev_lr) begin
            if (started) finish_channel(cap_chan, cap, ncap);
            started  = 1;
            cap      = '0;
            ncap     = 0;
            cap_chan = chan_num;
            prev_lr  = AUD_DACLRCK;
         end
         cap = {cap[30:0], AUD_DACDAT};
         ncap++;
      end
   end

   task automatic do_write(input logic [23:0] l, input logic [23:0] r);
      writedata_left  = l;
      writedata_right = r;
      write = 1'b1;
      @(negedge CLOCK_50);
      write = 1'b0;
   endtask

   task automatic count_uf(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge CLOCK_50);
         if (underflow) n++;
      end
   endtask

   logic [23:0] sl [5];
   logic [23:0] sr [5];

   initial begin
      int n;
      int base;
      int guard;
      sl[0] = 24'h123456; sr[0] = 24'hFEDCBA;
      sl[1] = 24'h000001; sr[1] = 24'hFFFFFF;
      sl[2] = 24'h555555; sr[2] = 24'hAAAAAA;
      sl[3] = 24'h800000; sr[3] = 24'h7FFFFF;
      sl[4] = 24'h0F0F0F; sr[4] = 24'hF0F0F0;

      reset = 1'b1;
      write = 1'b0;
      writedata_left = '0;
      writedata_right = '0;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_write_ready", write_ready, 0);
      chk("rst_dacdat", AUD_DACDAT, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_fifo_count", fifo_count, 0);
      repeat (10) @(negedge CLOCK_50);
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("write_ready_after_rst", write_ready, 1);

      // 1: single sample, extreme values
      @(posedge AUD_DACLRCK);
      repeat (5) @(negedge CLOCK_50);
      expect_ch(chan_num + 1, 32'h3FFFFF80, 32, "t1_left");
      expect_ch(chan_num + 2, 32'h40000080, 32, "t1_right");
      // 2: nothing written, the next frame is silent
      expect_ch(chan_num + 3, 32'h0, 32, "t2_left_zero");
      expect_ch(chan_num + 4, 32'h0, 32, "t2_right_zero");
      do_write(24'h7FFFFF, 24'h800001);
      chk("t1_count_one", fifo_count, 1);
      @(negedge AUD_DACLRCK);
      count_uf(20, n);
      chk("t1_no_underflow", n, 0);
      chk("t1_count_zero", fifo_count, 0);
      @(negedge AUD_DACLRCK);
      count_uf(20, n);
      chk("t2_underflow_pulse", n, 1);

      // 3: five pushes into a 4-deep FIFO
      @(posedge AUD_DACLRCK);
      repeat (5) @(negedge CLOCK_50);
      base = chan_num + 1;
      for (int i = 0; i < 4; i++) begin
         expect_ch(base + 2*i,     mk_exp(sl[i], 32), 32, "t3_left");
         expect_ch(base + 2*i + 1, mk_exp(sr[i], 32), 32, "t3_right");
      end
      expect_ch(base + 8, 32'h0, 32, "t3_left_drained");
      expect_ch(base + 9, 32'h0, 32, "t3_right_drained");
      for (int i = 0; i < 5; i++) begin
         writedata_left  = sl[i];
         writedata_right = sr[i];
         write = 1'b1;
         chk("t3_write_ready", write_ready, (i < 4) ? 1 : 0);
         @(negedge CLOCK_50);
      end
      write = 1'b0;
      chk("t3_count_full", fifo_count, 4);

      // 4: write in the same cycle as the pop while full
      @(negedge AUD_DACLRCK);
      repeat (2) @(negedge CLOCK_50);
      chk("t4_ready_low_at_pop", write_ready, 0);
      do_write(24'h111111, 24'h222222);
      chk("t4_count_three", fifo_count, 3);
      chk("t4_ready_after_pop", write_ready, 1);
      repeat (3) @(negedge AUD_DACLRCK);
      repeat (10) @(negedge CLOCK_50);
      chk("t3_count_drained", fifo_count, 0);
      @(negedge AUD_DACLRCK);
      count_uf(20, n);
      chk("t3_underflow_empty", n, 1);

      // 5: reset in the middle of a right-channel shift
      do_write(24'h13579B, 24'h2468AC);
      expect_ch(chan_num + 2, mk_exp(24'h13579B, 32), 32, "t5_left_before_reset");
      @(negedge AUD_DACLRCK);
      @(posedge AUD_DACLRCK);
      repeat (200) @(negedge CLOCK_50);
      do_write(24'h0BAD00, 24'h00BAD0);
      chk("t5_count_before_reset", fifo_count, 1);
      reset = 1'b1;
      write = 1'b1;
      writedata_left  = 24'h5A5A5A;
      writedata_right = 24'hA5A5A5;
      @(negedge CLOCK_50);
      chk("t5_dacdat_in_reset", AUD_DACDAT, 0);
      chk("t5_ready_in_reset", write_ready, 0);
      repeat (2) @(negedge CLOCK_50);
      chk("t5_count_in_reset", fifo_count, 0);
      reset = 1'b0;
      write = 1'b0;
      @(negedge CLOCK_50);
      chk("t5_ready_after_reset", write_ready, 1);
      expect_ch(chan_num + 1, mk_exp(24'h6B6B6B, 32), 32, "t5_left_after_reset");
      expect_ch(chan_num + 2, mk_exp(24'h94A5C3, 32), 32, "t5_right_after_reset");
      do_write(24'h6B6B6B, 24'h94A5C3);
      n = 0;
      guard = 0;
      while (AUD_DACLRCK == 1'b1 && guard < 2000) begin
         @(negedge CLOCK_50);
         if (AUD_DACDAT) n++;
         guard++;
      end
      chk("t5_quiet_until_left", n, 0);
      chk("t5_left_edge_seen", (guard < 2000) ? 1 : 0, 1);

      // 6: 16-BCLK channels truncate the 24-bit word
      @(posedge AUD_DACLRCK);
      repeat (5) @(negedge CLOCK_50);
      expect_ch(chan_num + 1, 32'h000055E6, 16, "t6_left_trunc");
      expect_ch(chan_num + 2, 32'h0000091A, 16, "t6_right_trunc");
      expect_ch(chan_num + 3, 32'h0, 32, "t6_left_zero");
      expect_ch(chan_num + 4, 32'h0, 32, "t6_right_zero");
      do_write(24'hABCDEF, 24'h123456);
      @(negedge AUD_DACLRCK);
      chan_len = 16;
      @(posedge AUD_DACLRCK);
      @(negedge AUD_DACLRCK);
      chan_len = 32;
      @(posedge AUD_DACLRCK);
      @(negedge AUD_DACLRCK);
      repeat (30) @(negedge CLOCK_50);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
